// File: rtl/ctrl_dbg_master_pkg.sv
// Shared definitions for the byte-stream debug master: FSM states,
// response status codes and command-byte field positions.
package ctrl_dbg_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADR,
        S_DAT,
        S_BUS,
        S_RSP,
        S_RDAT
    } state_e;

    typedef enum logic [7:0] {
        ST_OK  = 8'h00,
        ST_ERR = 8'h01,
        ST_TMO = 8'h02
    } status_e;

    localparam int CMD_WE     = 7;
    localparam int CMD_SEL_LO = 0;
    localparam int CMD_SEL_HI = 3;

    localparam int MAW_DEF = 14;
    localparam int QDW_DEF = 32;
    localparam int QSW_DEF = 4;
    localparam int TO_DEF  = 255;

endpackage

// File: rtl/ctrl_dbg_master_if.sv
// Command/response byte streams plus the control-bus master port of the
// debug master, bundled so the top and its environment share one view.
interface ctrl_dbg_master_if
    import ctrl_dbg_pkg::*;
#(
    parameter int MAW = MAW_DEF,
    parameter int QDW = QDW_DEF,
    parameter int QSW = QSW_DEF
);

    logic           rx_valid;
    logic           rx_ready;
    logic [7:0]     rx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [7:0]     tx_data;
    logic           m_cs;
    logic           m_we;
    logic [QSW-1:0] m_sel;
    logic [MAW-1:0] m_adr;
    logic [QDW-1:0] m_dat_w;
    logic [QDW-1:0] m_dat_r;
    logic           m_ack;
    logic           m_err;
    logic           busy;

    modport master (
        input  rx_valid, rx_data, tx_ready, m_dat_r, m_ack, m_err,
        output rx_ready, tx_valid, tx_data, m_cs, m_we, m_sel, m_adr, m_dat_w, busy
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, m_dat_r, m_ack, m_err,
        input  rx_ready, tx_valid, tx_data, m_cs, m_we, m_sel, m_adr, m_dat_w, busy
    );

endinterface

// File: rtl/ctrl_dbg_master.sv
// Debug master: parses framed command bytes, runs one control-bus read or
// write, and streams back a status byte plus read data.
module ctrl_dbg_master
    import ctrl_dbg_pkg::*;
#(
    parameter int MAW = MAW_DEF,
    parameter int QDW = QDW_DEF,
    parameter int QSW = QSW_DEF,
    parameter int TO  = TO_DEF
) (
    input logic              clk,
    input logic              rst_n,
    ctrl_dbg_master_if.master bus
);

    localparam int            TW       = $clog2(TO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TO - 1);

    state_e         r_state;
    state_e         w_next;
    logic           r_we;
    logic [QSW-1:0] r_sel;
    logic [7:0]     r_adrHi;
    logic [MAW-1:0] r_adr;
    logic [QDW-1:0] r_data;
    logic [1:0]     r_byteCnt;
    logic [TW-1:0]  r_tmoCnt;
    logic [7:0]     r_txData;

    logic w_rxReady;
    logic w_txValid;
    logic w_cs;
    logic w_busy;
    logic w_rxFire;
    logic w_txFire;
    logic w_done;
    logic w_timeout;

    assign w_rxFire  = bus.rx_valid & w_rxReady;
    assign w_txFire  = w_txValid & bus.tx_ready;
    assign w_done    = bus.m_ack | bus.m_err;
    assign w_timeout = (r_tmoCnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CMD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CMD:   if (w_rxFire) w_next = S_ADR;
            S_ADR:   if (w_rxFire && r_byteCnt == 2'd1) w_next = r_we ? S_DAT : S_BUS;
            S_DAT:   if (w_rxFire && r_byteCnt == 2'd3) w_next = S_BUS;
            S_BUS:   if (w_done || w_timeout) w_next = S_RSP;
            S_RSP:   if (w_txFire) w_next = r_we ? S_CMD : S_RDAT;
            S_RDAT:  if (w_txFire && r_byteCnt == 2'd3) w_next = S_CMD;
            default: w_next = S_CMD;
        endcase
    end

    always_comb begin
        w_rxReady = (r_state == S_CMD) || (r_state == S_ADR) || (r_state == S_DAT);
        w_txValid = (r_state == S_RSP) || (r_state == S_RDAT);
        w_cs      = (r_state == S_BUS);
        w_busy    = (r_state != S_CMD);
    end

    // One data register serves write payload, read capture and the RDAT shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adrHi   <= '0;
            r_adr     <= '0;
            r_data    <= '0;
            r_byteCnt <= '0;
            r_tmoCnt  <= '0;
            r_txData  <= '0;
        end else begin
            r_tmoCnt <= (r_state == S_BUS) ? r_tmoCnt + 1'b1 : '0;
            case (r_state)
                S_CMD: begin
                    if (w_rxFire) begin
                        r_we      <= bus.rx_data[CMD_WE];
                        r_sel     <= bus.rx_data[CMD_SEL_LO +: QSW];
                        r_byteCnt <= 2'd0;
                    end
                end
                S_ADR: begin
                    if (w_rxFire) begin
                        if (r_byteCnt == 2'd0) begin
                            r_adrHi <= bus.rx_data;
                        end else begin
                            r_adr <= MAW'({r_adrHi, bus.rx_data});
                        end
                        r_byteCnt <= (r_byteCnt == 2'd1) ? 2'd0 : r_byteCnt + 2'd1;
                    end
                end
                S_DAT: begin
                    if (w_rxFire) begin
                        r_data    <= {r_data[QDW-9:0], bus.rx_data};
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                S_BUS: begin
                    if (w_done) begin
                        r_txData <= bus.m_err ? ST_ERR : ST_OK;
                        if (!r_we) begin
                            r_data <= bus.m_err ? '0 : bus.m_dat_r;
                        end
                    end else if (w_timeout) begin
                        r_txData <= ST_TMO;
                        r_data   <= '0;
                    end
                end
                S_RSP: begin
                    if (w_txFire) begin
                        r_txData  <= r_data[QDW-1 -: 8];
                        r_data    <= r_data << 8;
                        r_byteCnt <= 2'd0;
                    end
                end
                S_RDAT: begin
                    if (w_txFire) begin
                        r_txData  <= r_data[QDW-1 -: 8];
                        r_data    <= r_data << 8;
                        r_byteCnt <= r_byteCnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready = w_rxReady;
    assign bus.tx_valid = w_txValid;
    assign bus.tx_data  = r_txData;
    assign bus.m_cs     = w_cs;
    assign bus.m_we     = r_we;
    assign bus.m_sel    = r_sel;
    assign bus.m_adr    = r_adr;
    assign bus.m_dat_w  = r_data;
    assign bus.busy     = w_busy;

endmodule

// File: tb/tb_ctrl_dbg_master.sv
// Scoreboard bench for ctrl_dbg_master: expected response bytes are queued as
// frames are sent and checked as the DUT emits them; a bus slave model answers.
module tb_ctrl_dbg_master;
    import ctrl_dbg_pkg::*;

    localparam int MAW = 14;
    localparam int QDW = 32;
    localparam int QSW = 4;
    localparam int TO  = 16;

    typedef logic [7:0] byteQ_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ctrl_dbg_master_if #(.MAW(MAW), .QDW(QDW), .QSW(QSW)) bus ();

    ctrl_dbg_master #(.MAW(MAW), .QDW(QDW), .QSW(QSW), .TO(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    int          ackAt    = 0;
    bit          errMode  = 1'b0;
    bit          tieAck   = 1'b0;
    int          csCycles = 0;
    int          unstable = 0;
    logic        capWe;
    logic [3:0]  capSel;
    logic [13:0] capAdr;
    logic [31:0] capDat;

    int         txCount     = 0;
    int         stallCycles = 0;
    int         rxViol      = 0;
    bit         prevStall   = 1'b0;
    logic [7:0] heldData;
    logic [7:0] expByte;

    // Slave model: counts cs cycles, latches the request and answers at a chosen cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.m_ack = 1'b0;
            bus.m_err = 1'b0;
        end else if (bus.m_cs) begin
            csCycles++;
            if (csCycles == 1) begin
                capWe  = bus.m_we;
                capSel = bus.m_sel;
                capAdr = bus.m_adr;
                capDat = bus.m_dat_w;
            end else if (capWe !== bus.m_we || capSel !== bus.m_sel ||
                         capAdr !== bus.m_adr || capDat !== bus.m_dat_w) begin
                unstable++;
            end
            if (tieAck || (ackAt != 0 && csCycles == ackAt)) begin
                bus.m_ack = 1'b1;
                bus.m_err = errMode;
            end else begin
                bus.m_ack = 1'b0;
                bus.m_err = 1'b0;
            end
        end else begin
            bus.m_ack = tieAck;
            bus.m_err = 1'b0;
        end
    end

    // Response monitor: pops the scoreboard on every accepted byte, watches stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checks++;
                if (bus.tx_data !== heldData) begin
                    errors++;
                    $display("[TB] FAIL stall_hold tx_data=%h held=%h", bus.tx_data, heldData);
                end
            end
            if (bus.tx_valid && !bus.tx_ready) stallCycles++;
            prevStall = bus.tx_valid && !bus.tx_ready;
            heldData  = bus.tx_data;
            if ((bus.m_cs || bus.tx_valid) && bus.rx_ready) rxViol++;
            if (bus.tx_valid && bus.tx_ready) begin
                checks++;
                txCount++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL tx_unexpected got=%h expected=none", bus.tx_data);
                end else begin
                    expByte = expQ.pop_front();
                    if (bus.tx_data !== expByte) begin
                        errors++;
                        $display("[TB] FAIL tx_byte got=%h expected=%h", bus.tx_data, expByte);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = bus.rx_ready;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL rx_accept byte=%h got=stuck expected=accepted", b);
        end
    endtask

    task automatic sendFrame(input byteQ_t f, input int gap);
        foreach (f[i]) applyStimulus(f[i], gap);
    endtask

    task automatic waitIdle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0 && !bus.busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_idle got=busy pending=%0d expected=idle", name, expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkBus(input string name, input int cs, input logic we,
                            input logic [3:0] sel, input logic [13:0] adr);
        checks++;
        if (csCycles !== cs) begin
            errors++;
            $display("[TB] FAIL %s_cs_cycles got=%0d expected=%0d", name, csCycles, cs);
        end
        checks++;
        if (capWe !== we || capSel !== sel || capAdr !== adr) begin
            errors++;
            $display("[TB] FAIL %s_request got we=%b sel=%h adr=%h expected we=%b sel=%h adr=%h",
                     name, capWe, capSel, capAdr, we, sel, adr);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("[TB] FAIL %s_stable got=%0d changes expected=0", name, unstable);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.m_cs !== 1'b0 || bus.m_we !== 1'b0 || bus.m_sel !== 4'h0 || bus.m_adr !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus got cs=%b we=%b sel=%h adr=%h expected all zero",
                     bus.m_cs, bus.m_we, bus.m_sel, bus.m_adr);
        end
        checks++;
        if (bus.m_dat_w !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_dat_w got=%h expected=00000000", bus.m_dat_w);
        end
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_stream got tx_valid=%b tx_data=%h busy=%b rx_ready=%b expected 0 00 0 1",
                     bus.tx_valid, bus.tx_data, bus.busy, bus.rx_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        byteQ_t f;
        tieAck = 1'b1; errMode = 1'b0; ackAt = 0; csCycles = 0; unstable = 0;
        expQ.push_back(8'h00);
        f = '{8'h8F, 8'h01, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sendFrame(f, 0);
        waitIdle("write");
        checkBus("write", 1, 1'b1, 4'hF, 14'h0120);
        checks++;
        if (capDat !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_dat_w got=%h expected=deadbeef", capDat);
        end
        tieAck = 1'b0;
    endtask

    task automatic test_read();
        byteQ_t f;
        ackAt = 3; errMode = 1'b0; csCycles = 0; unstable = 0;
        bus.m_dat_r = 32'h12345678;
        expQ.push_back(8'h00); expQ.push_back(8'h12); expQ.push_back(8'h34);
        expQ.push_back(8'h56); expQ.push_back(8'h78);
        f = '{8'h0F, 8'h00, 8'h40};
        sendFrame(f, 0);
        waitIdle("read");
        checkBus("read", 3, 1'b0, 4'hF, 14'h0040);
    endtask

    task automatic test_error();
        byteQ_t f;
        ackAt = 1; errMode = 1'b1; csCycles = 0; unstable = 0;
        bus.m_dat_r = 32'hAAAAAAAA;
        expQ.push_back(8'h01);
        repeat (4) expQ.push_back(8'h00);
        f = '{8'h03, 8'h3F, 8'hFF};
        sendFrame(f, 0);
        waitIdle("error");
        checkBus("error", 1, 1'b0, 4'h3, 14'h3FFF);
        errMode = 1'b0;
    endtask

    task automatic test_timeout();
        byteQ_t f;
        ackAt = 0; csCycles = 0; unstable = 0;
        bus.m_dat_r = 32'h55555555;
        expQ.push_back(8'h02);
        repeat (4) expQ.push_back(8'h00);
        f = '{8'h0F, 8'h00, 8'h10};
        sendFrame(f, 0);
        waitIdle("timeout");
        checkBus("timeout", TO, 1'b0, 4'hF, 14'h0010);
        ackAt = 2; csCycles = 0; unstable = 0;
        expQ.push_back(8'h00);
        f = '{8'h81, 8'hC0, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
        sendFrame(f, 0);
        waitIdle("after_tmo");
        checkBus("after_tmo", 2, 1'b1, 4'h1, 14'h0008);
        checks++;
        if (capDat !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL after_tmo_dat_w got=%h expected=01020304", capDat);
        end
    endtask

    task automatic test_backpressure();
        byteQ_t f;
        int startCount;
        ackAt = 2; csCycles = 0; unstable = 0; rxViol = 0; stallCycles = 0;
        bus.m_dat_r = 32'hA1B2C3D4;
        expQ.push_back(8'h00); expQ.push_back(8'hA1); expQ.push_back(8'hB2);
        expQ.push_back(8'hC3); expQ.push_back(8'hD4);
        f = '{8'h0F, 8'h01, 8'h00};
        startCount = txCount;
        fork
            begin
                sendFrame(f, 2);
                waitIdle("backpressure");
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 500 && !seen; i++) begin
                    @(negedge clk);
                    #1;
                    if (txCount >= startCount + 2) seen = 1'b1;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("[TB] FAIL bp_rdat_reach got=%0d bytes expected=2", txCount - startCount);
                end
                @(posedge clk);
                #1;
                bus.tx_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.tx_ready = 1'b1;
            end
        join
        checkBus("backpressure", 2, 1'b0, 4'hF, 14'h0100);
        checks++;
        if (stallCycles !== 5) begin
            errors++;
            $display("[TB] FAIL bp_stall_cycles got=%0d expected=5", stallCycles);
        end
        checks++;
        if (rxViol !== 0) begin
            errors++;
            $display("[TB] FAIL bp_rx_ready got=%0d busy-ready cycles expected=0", rxViol);
        end
    endtask

    task automatic test_reset_mid();
        byteQ_t f;
        bit seen = 1'b0;
        ackAt = 0; csCycles = 0; unstable = 0;
        expQ.push_back(8'h02);
        f = '{8'h0F, 8'h00, 8'h20};
        sendFrame(f, 0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_cs) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL rstmid_cs got=0 expected=1");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.m_cs !== 1'b0 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_async got cs=%b tx_valid=%b busy=%b rx_ready=%b expected 0 0 0 1",
                     bus.m_cs, bus.tx_valid, bus.busy, bus.rx_ready);
        end
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ackAt = 1; csCycles = 0; unstable = 0;
        expQ.push_back(8'h00);
        f = '{8'h8F, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        sendFrame(f, 0);
        waitIdle("rstmid_write");
        checkBus("rstmid_write", 1, 1'b1, 4'hF, 14'h0004);
        checks++;
        if (capDat !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL rstmid_dat_w got=%h expected=11223344", capDat);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        bus.m_dat_r  = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ctrl_dbg_master.md
# ctrl_dbg_master

Byte-stream debug master for the control bus. Accepts framed command bytes (e.g. from a host UART/JTAG front end) on a valid/ready stream, issues single read or write transactions as a second master on the control bus (same cs/we/sel/adr/dat_w/dat_r/ack/err protocol the CPU data port uses), and returns status and read data as response bytes. It lets a host poke regs/RAM (Mandelbrot parameters, console, program upload) without CPU involvement.

## Interface
- MAW, 14: bus address width (≤16; upper address-byte bits beyond MAW ignored)
- QDW, 32: bus data width (fixed 32)
- QSW, 4: byte-select width
- TO, 255: bus timeout in cycles (≥2)
- clk  in  1  system clock
- rst  in  1  reset; **asynchronous, active-low**
- rx_valid  in  1  command byte valid
- rx_ready  out  1  command byte accepted when rx_valid & rx_ready
- rx_data  in  8  command byte
- tx_valid  out  1  response byte valid
- tx_ready  in  1  response sink ready
- tx_data  out  8  response byte
- m_cs  out  1  bus request
- m_we  out  1  write enable
- m_sel  out  QSW  byte selects
- m_adr  out  MAW  byte address
- m_dat_w  out  QDW  write data
- m_dat_r  in  QDW  read data, sampled in completion cycle
- m_ack  in  1  transaction done OK
- m_err  in  1  transaction done with error
- busy  out  1  high in any state other than CMD

## Operation
- Frame (big-endian): CMD byte [7]=we, [6:4] ignored, [3:0]=sel; ADR_H, ADR_L; if we: D3,D2,D1,D0.
- Response: status byte (0x00 ok, 0x01 err, 0x02 timeout); reads follow with 4 data bytes MSB first (zeros on err/timeout); writes return status only.
- States: CMD → ADR (2 bytes) → DAT (4 bytes, writes only) → BUS → RSP → RDAT (4 bytes, reads only) → CMD.
- 2-bit byte counter in ADR/DAT/RDAT; data shifted into 32-bit register; same register reloaded with m_dat_r on read completion and shifted out in RDAT.
- BUS: m_cs high; m_we/m_sel/m_adr/m_dat_w stable for whole BUS state. Completion = first cycle with m_ack|m_err. m_err wins if both high.
- Timeout counter cleared on BUS entry, increments each BUS cycle; if TO cycles elapse with no ack/err, m_cs drops, status 0x02.
- sel=0 transactions issued as-is.

## Timing
- Reset values: m_cs=0, m_we=0, m_sel=0, m_adr=0, m_dat_w=0, tx_valid=0, tx_data=0, busy=0; state=CMD; counters 0.
- rx_ready decoded from state: 1 in CMD/ADR/DAT, 0 in BUS/RSP/RDAT.
- m_cs rises the cycle after the handshake of the last frame byte; ack in that same first cycle is legal (1-cycle transaction).
- m_cs falls the cycle after completion; no back-to-back cs without returning through CMD.
- tx_valid rises the cycle after completion; tx_data registered, held stable until tx_valid & tx_ready; next byte presented the following cycle.
- Min write round trip: 7 rx bytes + 1 BUS + 1 RSP cycle.
- Reset mid-operation: outputs go to reset values immediately (async); partial frame/response discarded.
- m_ack/m_err outside BUS ignored.

## Structure
- Package ctrl_dbg_pkg: state encoding, status codes (OK/ERR/TMO), CMD bit positions (WE=7, SEL=3:0).
- Single module, no sub-modules; shift/data register and counters inline.

## Test plan
- Write: rx 8F 01 20 DE AD BE EF, m_ack tied 1 → m_cs exactly 1 cycle, m_adr=0x0120, m_sel=F, m_dat_w=0xDEADBEEF, m_we=1; tx 00.
- Read: rx 0F 00 40, m_ack after 3 cs cycles with m_dat_r=0x12345678 → m_cs 3 cycles, tx 00 12 34 56 78.
- Error: read with m_err and m_ack both high in first cs cycle → tx 01 00 00 00 00.
- Timeout: TO=16, slave silent → m_cs high exactly 16 cycles, tx 02 00 00 00 00, then next command works.
- Backpressure: rx_valid gaps, tx_ready low 5 cycles mid-RDAT → tx_data stable while stalled, no bytes lost/duplicated, rx_ready=0 throughout BUS/RSP/RDAT.
- Reset low during BUS → m_cs=0 and tx_valid=0 asynchronously; after release a fresh write frame completes with status 00.
